// File: rtl/memoria_instrucao_sinc.sv
// memoria_instrucao_sinc -- synchronous instruction memory with a self-clearing
// init sweep and a programming write port.
//
// Parameters:
//   DEPTH     number of instruction words
//   WORD_W    instruction width in bits
//   PC_W      pc width in bits
//   BYTE_ADDR 1: pc is a byte address (word index = pc>>2); 0: pc is a word index
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high; restarts the clearing sweep
//   pc         fetch address
//   req        fetch request (accepted when ready=1 and stall=0)
//   stall      freezes instrucao/valid/fault and ignores req
//   instrucao  registered fetched word (0 on fault or idle)
//   valid      instrucao/fault belong to the previous accepted fetch
//   fault      previous accepted fetch was out of range or misaligned
//   ready      clearing sweep complete; fetches and programming accepted
//   prog_we    programming write enable (honoured in READY, even when stalled)
//   prog_addr  programming word index
//   prog_data  programming data
module memoria_instrucao_sinc #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned PC_W      = 64,
  parameter int unsigned BYTE_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PC_W-1:0]          pc,
  input  logic                     req,
  input  logic                     stall,
  output logic [WORD_W-1:0]        instrucao,
  output logic                     valid,
  output logic                     fault,
  output logic                     ready,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [WORD_W-1:0]        prog_data
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] counter, counter_nxt;
  logic              sweep_we;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic              prog_in_range;

  logic [PC_W-1:0]   idx;
  logic [ADDR_W-1:0] raddr;
  logic              misaligned;
  logic              out_of_range;
  logic              fetch_fault;

  // ---------------------------------------------------------------------------
  // Control FSM: INIT clears one word per cycle, then READY.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    sweep_we    = 1'b0;
    case (state)
      INIT: begin
        sweep_we = 1'b1;
        // The edge that clears the last word also enters READY, so the
        // sweep occupies exactly DEPTH cycles.
        if (counter == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = READY;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + 1'b1;
        end
      end
      READY: begin
      end
      default: state_nxt = INIT;
    endcase
  end

  assign ready = (state == READY);

  // ---------------------------------------------------------------------------
  // Single write port shared by the sweep and the programming interface.
  // ---------------------------------------------------------------------------
  assign prog_in_range = ({1'b0, prog_addr} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (!reset) begin
      if (sweep_we) begin
        mem_we    = 1'b1;
        mem_waddr = counter;
        mem_wdata = '0;
      end else if (prog_we && prog_in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch decode: full-width range compare so high pc bits cannot alias.
  // ---------------------------------------------------------------------------
  assign idx          = (BYTE_ADDR != 0) ? (pc >> 2) : pc;
  assign raddr        = idx[ADDR_W-1:0];
  assign misaligned   = (BYTE_ADDR != 0) && (pc[1:0] != 2'b00);
  assign out_of_range = (idx >= PC_W'(DEPTH));
  assign fetch_fault  = misaligned || out_of_range;

  // Reads sample mem before this edge's write lands, giving read-first
  // behaviour for a same-cycle fetch and write to one word.
  always_ff @(posedge clk) begin
    if (reset || state == INIT) begin
      instrucao <= '0;
      valid     <= 1'b0;
      fault     <= 1'b0;
    end else if (!stall) begin
      if (req) begin
        valid     <= 1'b1;
        fault     <= fetch_fault;
        instrucao <= fetch_fault ? '0 : mem[raddr];
      end else begin
        valid     <= 1'b0;
        fault     <= 1'b0;
        instrucao <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memoria_instrucao_sinc.sv
module tb_memoria_instrucao_sinc;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pc = '0;
  logic        req = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instrucao;
  logic        valid;
  logic        fault;
  logic        ready;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int unsigned sweep_left = 0;
  logic        exp_valid = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_instr = '0;

  memoria_instrucao_sinc #(
    .DEPTH(64),
    .WORD_W(32),
    .PC_W(64),
    .BYTE_ADDR(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .req(req),
    .stall(stall),
    .instrucao(instrucao),
    .valid(valid),
    .fault(fault),
    .ready(ready),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic rq, input logic [63:0] a, input logic st,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd);
    logic bad;
    reset = r; req = rq; pc = a; stall = st;
    prog_we = we; prog_addr = wa; prog_data = wd;

    if (r) begin
      exp_valid = 1'b0; exp_fault = 1'b0; exp_instr = '0;
      sweep_left = DEPTH;
    end else if (sweep_left != 0) begin
      exp_valid = 1'b0; exp_fault = 1'b0; exp_instr = '0;
      ref_mem[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (!st) begin
        if (rq) begin
          bad = (a % 4 != 0) || (a / 4 >= 64'(DEPTH));
          exp_valid = 1'b1;
          exp_fault = bad;
          exp_instr = bad ? 32'h0 : ref_mem[a / 4];
        end else begin
          exp_valid = 1'b0; exp_fault = 1'b0; exp_instr = '0;
        end
      end
      if (we && int'(wa) < DEPTH) ref_mem[wa] = wd;
    end

    @(posedge clk);
    #1;
    chk("ready", 64'(ready), 64'(sweep_left == 0));
    chk("valid", 64'(valid), 64'(exp_valid));
    chk("fault", 64'(fault), 64'(exp_fault));
    chk("instrucao", 64'(instrucao), 64'(exp_instr));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic fetch(input logic [63:0] a);
    step(1'b0, 1'b1, a, 1'b0, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic prog(input logic [5:0] wa, input logic [31:0] wd);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, wa, wd);
  endtask

  // Call right after a reset step: counts cycles with ready low, bounded.
  task automatic wait_sweep(input string tag);
    int unsigned n;
    n = (ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 200 && ready !== 1'b1; i++) begin
      idle();
      if (ready !== 1'b1) n++;
    end
    chk({tag, "_low_cycles"}, 64'(n), 64'(DEPTH));
    chk({tag, "_ready_up"}, 64'(ready), 64'd1);
  endtask

  logic [63:0] rpc;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);

    // Reset and sweep length
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 6'h0, 32'h0);
    wait_sweep("sweep1");
    for (int i = 0; i < 8; i++) fetch(64'(i * 36) & 64'hFC);
    fetch(64'd252);

    // Program then fetch
    prog(6'd1, 32'h00100103);
    fetch(64'd4);
    chk("prog_word1", 64'(instrucao), 64'h00100103);

    // Fault cases
    fetch(64'd256);
    chk("fault_256", 64'(fault), 64'd1);
    fetch(64'd6);
    chk("fault_misalign", 64'(fault), 64'd1);
    fetch(64'h1_0000_0004);
    chk("fault_high_bits", 64'(fault), 64'd1);

    // Read-first on same-cycle write/fetch
    step(1'b0, 1'b1, 64'd8, 1'b0, 1'b1, 6'd2, 32'hDEADBEEF);
    chk("read_first_old", 64'(instrucao), 64'h0);
    fetch(64'd8);
    chk("read_after_write", 64'(instrucao), 64'hDEADBEEF);

    // Stall holds outputs; write during stall still honoured
    fetch(64'd4);
    step(1'b0, 1'b1, 64'd8, 1'b1, 1'b0, 6'h0, 32'h0);
    step(1'b0, 1'b1, 64'd6, 1'b1, 1'b1, 6'd3, 32'h12345678);
    step(1'b0, 1'b1, 64'd12, 1'b1, 1'b0, 6'h0, 32'h0);
    chk("stall_frozen", 64'(instrucao), 64'h00100103);
    fetch(64'd12);
    chk("stall_write", 64'(instrucao), 64'h12345678);

    // Reset mid-sweep at counter=30
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 6'h0, 32'h0);
    for (int i = 0; i < 30; i++) idle();
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 6'h0, 32'h0);
    wait_sweep("sweep_mid");

    // Reset in READY with a fetch in flight
    prog(6'd5, 32'hCAFEF00D);
    fetch(64'd20);
    step(1'b1, 1'b1, 64'd20, 1'b0, 1'b0, 6'h0, 32'h0);
    chk("reset_abort_valid", 64'(valid), 64'd0);
    wait_sweep("sweep_ready");
    fetch(64'd20);
    chk("cleared_after_sweep", 64'(instrucao), 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rpc = 64'($urandom_range(0, 63)) << 2;
        6:                rpc = (64'($urandom_range(0, 63)) << 2) | 64'($urandom_range(1, 3));
        7:                rpc = 64'($urandom_range(256, 4096));
        8:                rpc = {$urandom, $urandom};
        default:          rpc = 64'($urandom_range(60, 70)) << 2;
      endcase
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1, rpc,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           6'($urandom_range(0, 63)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memoria_instrucao_sinc.md
MEMORIA_INSTRUCAO_SINC -- requirements
Module: memoria_instrucao_sinc

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 64, the number of instruction words.
REQ-002 The block SHALL provide parameter WORD_W, default 32, the instruction width in bits.
REQ-003 The block SHALL provide parameter PC_W, default 64, the pc width in bits.
REQ-004 The block SHALL provide parameter BYTE_ADDR, default 1: 1 = pc is a byte address (word index = pc>>2); 0 = pc is a word index.
REQ-005 The block SHALL provide port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL provide port pc, input, PC_W bits: fetch address.
REQ-008 The block SHALL provide port req, input, 1 bit: fetch request, sampled each edge.
REQ-009 The block SHALL provide port stall, input, 1 bit: hold all outputs and ignore req.
REQ-010 The block SHALL provide port instrucao, output, WORD_W bits: fetched word, registered.
REQ-011 The block SHALL provide port valid, output, 1 bit: instrucao/fault correspond to the previous accepted req.
REQ-012 The block SHALL provide port fault, output, 1 bit: the previous accepted fetch was out of range or misaligned.
REQ-013 The block SHALL provide port ready, output, 1 bit: init sweep is complete and the block accepts req and programming writes.
REQ-014 The block SHALL provide port prog_we, input, 1 bit: programming write enable.
REQ-015 The block SHALL provide port prog_addr, input, clog2(DEPTH) bits: programming word index.
REQ-016 The block SHALL provide port prog_data, input, WORD_W bits: programming data.

Function
REQ-017 The block SHALL implement a state machine with states INIT and READY; reset forces INIT with the sweep counter at 0.
REQ-018 In INIT, the block SHALL write 0 to word[counter] every cycle and increment the counter; after writing word DEPTH-1 it SHALL enter READY on the next edge. The sweep takes exactly DEPTH cycles.
REQ-019 In INIT, the block SHALL keep ready=0, ignore req and prog_we, and hold valid=0.
REQ-020 An accepted fetch SHALL be a cycle with ready=1, req=1 and stall=0.
REQ-021 Read latency SHALL be one cycle: on the edge after an accepted fetch, valid=1 and instrucao=word[idx].
REQ-022 A fetch SHALL fault when idx >= DEPTH (full PC_W compare, no truncation), or when BYTE_ADDR=1 and pc[1:0]!=0. A faulted fetch SHALL give valid=1, fault=1, instrucao=0.
REQ-023 A non-faulted fetch SHALL give fault=0.
REQ-024 Non-stalled cycles in READY with req=0 SHALL give valid=0, fault=0 and instrucao=0.
REQ-025 When stall=1, instrucao, valid and fault SHALL hold their previous values; prog_we remains honoured.
REQ-026 In READY, prog_we=1 SHALL write prog_data to word[prog_addr] at the edge; if prog_addr >= DEPTH, the write SHALL be ignored.
REQ-027 When a fetch and a write target the same word in the same cycle, the fetch SHALL return the old contents (read-first); the new value SHALL be visible to fetches accepted on later cycles.
REQ-028 Memory contents SHALL be preserved across reset except through the INIT sweep, which clears every word.

Reset
REQ-029 Reset SHALL take priority over all inputs.
REQ-030 After reset: instrucao=0, valid=0, fault=0, ready=0, state=INIT, counter=0.
REQ-031 Reset asserted during READY or mid-sweep SHALL abort any fetch in flight (valid=0 next cycle) and restart the sweep from word 0.

Verification
REQ-032 Assert reset 1 cycle, then release -> ready=0 for exactly 64 cycles, then ready=1; a fetch of any word in range returns 0 with fault=0.
REQ-033 Program word 1 = 0x00100103, then fetch pc=4 (BYTE_ADDR=1) -> next cycle valid=1, fault=0, instrucao=0x00100103.
REQ-034 Fetch pc=256, then pc=6, then pc=0x1_0000_0004 -> valid=1, fault=1, instrucao=0 each time.
REQ-035 Write word 2 = 0xDEADBEEF and fetch pc=8 in the same cycle -> old value returned; a fetch of pc=8 on the next cycle returns 0xDEADBEEF.
REQ-036 Accepted fetch followed by stall=1 for 3 cycles with req=1 -> outputs frozen for 3 cycles; after stall drops, fetches resume with 1-cycle latency.
REQ-037 Assert reset mid-sweep (counter=30) and again in READY with a fetch in flight -> valid=0 next cycle; ready rises only after a full 64-cycle sweep; previously programmed words read 0.
